cpu_trace_fifo: RTL and testbench

Downstream trace stage for the single-cycle `CPU`. It samples the CPU's per-cycle retirement outputs (`pc`, `inst`, `aluout`, `memout`) into a circular buffer, optionally starting at a trigger PC. A consumer drains the buffer over a valid/ready handshake. It sits beside the CPU at top level and gives the bench and debug logic an ordered execution history without probing CPU internals.

---
 rtl/cpu_trace_fifo.sv | 135 +++++++++++++
 tb/tb_cpu_trace_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_fifo.sv
// Execution-trace buffer for the single-cycle CPU: samples {pc, inst, aluout, memout}
// into a circular buffer (optionally from a trigger PC) and drains it FWFT over valid/ready.
module cpu_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          cap_en,
    input  logic          trig_en,
    input  logic [31:0]   trig_pc,
    input  logic [31:0]   pc,
    input  logic [31:0]   inst,
    input  logic [31:0]   aluout,
    input  logic [31:0]   memout,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic [31:0]   rd_alu,
    output logic [31:0]   rd_mem,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [15:0]   dropped,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10
    } state_t;

    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [15:0]   r_dropped;
    logic          w_capture;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [127:0]  w_head;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = cap_en ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
                if (!cap_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (!trig_en || (pc == trig_pc)) begin
                    w_state_nxt = ST_CAPTURE;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = cap_en ? ST_CAPTURE : ST_IDLE;
                w_capture   = cap_en;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_pop  = !empty && rd_ready;
    assign w_push = w_capture && (!full || w_pop);
    assign w_drop = w_capture && full && !w_pop;

    // NOTE: the sample array has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pc, inst, aluout, memout};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
        end
    end

    // First-word-fall-through: the head entry is visible without a read cycle.
    assign w_head   = r_mem[r_rd_ptr];
    assign rd_pc    = w_head[127:96];
    assign rd_inst  = w_head[95:64];
    assign rd_alu   = w_head[63:32];
    assign rd_mem   = w_head[31:0];

    assign count    = r_count;
    assign full     = (r_count == C_FULL);
    assign empty    = (r_count == '0);
    assign rd_valid = !empty;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Self-checking bench for cpu_trace_fifo: directed vector table, hand sequences for
// fill/trigger/overflow/wrap/reset, and randomized traffic against a queue-based model.
module tb_cpu_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          clrn, cap_en, trig_en, rd_ready;
    logic [31:0]   trig_pc, pc, inst, aluout, memout;
    logic          rd_valid, full, empty, overflow;
    logic [31:0]   rd_pc, rd_inst, rd_alu, rd_mem;
    logic [AW:0]   count;
    logic [15:0]   dropped;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capture; contents as a queue of entries.
    int            m_state;
    logic [127:0]  m_q[$];
    logic          m_overflow;
    int            m_dropped;

    cpu_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .clrn(clrn), .cap_en(cap_en), .trig_en(trig_en), .trig_pc(trig_pc),
        .pc(pc), .inst(inst), .aluout(aluout), .memout(memout),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_alu(rd_alu), .rd_mem(rd_mem),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .dropped(dropped), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clrn;
        logic        cap_en;
        logic        trig_en;
        logic        rd_ready;
        logic [31:0] trig_pc;
        logic [31:0] pc;
        logic [1:0]  exp_state;
        int          exp_count;
        logic [31:0] exp_head;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic c, input logic ce, input logic te, input logic rr,
                          input logic [31:0] tp, input logic [31:0] p);
        clrn     = c;
        cap_en   = ce;
        trig_en  = te;
        rd_ready = rr;
        trig_pc  = tp;
        pc       = p;
        inst     = p ^ 32'hA5A5_0000;
        aluout   = p + 32'd100;
        memout   = ~p;
    endtask

    function automatic void model_edge();
        bit pop, cap, hit, at_full;
        if (clrn) begin
            m_state    = 0;
            m_q.delete();
            m_overflow = 1'b0;
            m_dropped  = 0;
            return;
        end
        hit     = !trig_en || (pc == trig_pc);
        cap     = cap_en && ((m_state == 1 && hit) || m_state == 2);
        pop     = (m_q.size() > 0) && rd_ready;
        at_full = (m_q.size() == DEPTH);
        if (!cap_en)           m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = hit ? 2 : 1;
        else                   m_state = 2;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (!at_full || pop) begin
                m_q.push_back({pc, inst, aluout, memout});
            end else begin
                m_overflow = 1'b1;
                if (m_dropped < 16'hFFFF) m_dropped++;
            end
        end
    endfunction

    task automatic check_all();
        logic [127:0] h;
        check("state", state, m_state);
        check("count", count, m_q.size());
        check("empty", empty, m_q.size() == 0);
        check("full", full, m_q.size() == DEPTH);
        check("rd_valid", rd_valid, m_q.size() != 0);
        check("overflow", overflow, m_overflow);
        check("dropped", dropped, m_dropped);
        if (m_q.size() > 0) begin
            h = m_q[0];
            check("rd_pc", rd_pc, h[127:96]);
            check("rd_inst", rd_inst, h[95:64]);
            check("rd_alu", rd_alu, h[63:32]);
            check("rd_mem", rd_mem, h[31:0]);
        end
    endtask

    // Inputs change only around the falling edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();
        clrn = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        m_state    = 0;
        m_overflow = 1'b0;
        m_dropped  = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Trigger at 0x10: arming cycles, trigger sample first, late match ignored, drain in IDLE.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h00, 2'd0, 0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h00, 2'd1, 0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h04, 2'd1, 0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h08, 2'd1, 0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0C, 2'd1, 0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10, 2'd2, 1, 32'h10};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 2'd2, 2, 32'h10};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h18, 2'd2, 3, 32'h10};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10, 2'd2, 4, 32'h10};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1C, 2'd0, 4, 32'h10};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h20, 2'd0, 3, 32'h14};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].clrn, vecs[i].cap_en, vecs[i].trig_en, vecs[i].rd_ready,
                   vecs[i].trig_pc, vecs[i].pc);
            cycle();
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            if (vecs[i].exp_count > 0) check($sformatf("vec%0d_head", i), rd_pc, vecs[i].exp_head);
        end

        // Free-run fill: one arming edge, then pc 0..16 captured; drain in order.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFC);
        cycle();
        check("fr_armed", state, 2'd1);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'(4 * i));
            cycle();
        end
        check("fr_count", count, 5);
        check("fr_state", state, 2'd2);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fr_drain%0d_pc", i), rd_pc, 32'(4 * i));
            check($sformatf("fr_drain%0d_alu", i), rd_alu, 32'(4 * i + 100));
            cycle();
        end
        check("fr_empty", empty, 1'b1);

        // Overflow: 20 captures with no reads, then full with simultaneous push and pop.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFC);
        cycle();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100 + 32'(4 * i));
            cycle();
        end
        check("ov_count", count, DEPTH);
        check("ov_full", full, 1'b1);
        check("ov_flag", overflow, 1'b1);
        check("ov_dropped", dropped, 16'd4);
        check("ov_head", rd_pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pp%0d_head", i), rd_pc, 32'h100 + 32'(4 * i));
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200 + 32'(4 * i));
            cycle();
        end
        check("pp_count", count, DEPTH);
        check("pp_dropped", dropped, 16'd4);
        check("pp_head", rd_pc, 32'h10C);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 13; i++) cycle();
        check("ov_tail16", rd_pc, 32'h200);
        for (int i = 0; i < 3; i++) cycle();
        check("ov_sticky", overflow, 1'b1);

        // Wrap-around: fill 10, drain 10, fill 12, drain 12 in order.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFC);
        cycle();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300 + 32'(4 * i));
            cycle();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) cycle();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFC);
        cycle();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h400 + 32'(4 * i));
            cycle();
        end
        check("wr_count", count, 12);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            exp_pc = 32'h400 + 32'(4 * i);
            check($sformatf("wr_drain%0d", i), rd_pc, exp_pc);
            cycle();
        end
        check("wr_empty", empty, 1'b1);

        // Reset mid-capture with seven entries held.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFC);
        cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h500 + 32'(4 * i));
            cycle();
        end
        check("rm_pre_count", count, 7);
        clrn = 1'b1;
        cycle();
        check("rm_state", state, 2'd0);
        check("rm_count", count, 0);
        check("rm_empty", empty, 1'b1);
        check("rm_overflow", overflow, 1'b0);
        check("rm_dropped", dropped, 16'd0);
        clrn = 1'b0;
        cycle();
        check("rm_rearm", state, 2'd1);

        // Randomized traffic against the model; read pressure varies by phase.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ready_odds;
            ready_odds = (i / 500) % 3;
            clrn     = ($urandom_range(0, 499) == 0);
            cap_en   = ($urandom_range(0, 9) != 0);
            trig_en  = $urandom_range(0, 1) == 1;
            trig_pc  = 32'h40;
            pc       = 32'($urandom_range(0, 31) * 4);
            inst     = $urandom;
            aluout   = $urandom;
            memout   = $urandom;
            rd_ready = ($urandom_range(0, ready_odds) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
